// File: rtl/sd_cmd_ctrl.sv
// SD SPI command sequencer: power-up dummy bytes, 6-byte command frame, then R1 polling
// with an Ncr timeout, all driven through a one-byte start/done engine.
module sd_cmd_ctrl #(
    parameter int unsigned DUMMY_BYTES = 10,
    parameter int unsigned MAX_POLL    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [5:0]  cmd_idx,
    input  logic [31:0] cmd_arg,
    input  logic [6:0]  cmd_crc,
    output logic        cmd_ready,
    output logic        resp_valid,
    output logic [7:0]  resp_r1,
    output logic        resp_timeout,
    output logic        busy,
    output logic        byte_start,
    output logic [7:0]  byte_tx,
    input  logic [7:0]  byte_rx,
    input  logic        byte_done
);

    localparam int unsigned DummyW = $clog2(DUMMY_BYTES + 1);
    localparam int unsigned PollW  = $clog2(MAX_POLL + 1);
    localparam logic [DummyW-1:0] DummyLast = DummyW'(DUMMY_BYTES - 1);
    localparam logic [PollW-1:0]  PollLast  = PollW'(MAX_POLL - 1);

    typedef enum logic [2:0] {
        StDummyIssue,
        StDummyWait,
        StIdle,
        StSendIssue,
        StSendWait,
        StPollIssue,
        StPollWait,
        StResp
    } state_e;

    state_e            state;
    logic [DummyW-1:0] dummy_cnt;
    logic [PollW-1:0]  poll_cnt;
    logic [2:0]        byte_idx;
    logic [5:0]        idx_q;
    logic [31:0]       arg_q;
    logic [6:0]        crc_q;
    logic [7:0]        frame_byte;

    // Frame byte for the current position, built from the latched command fields.
    always_comb begin
        frame_byte = 8'hFF;
        case (byte_idx)
            3'd0:    frame_byte = {2'b01, idx_q};
            3'd1:    frame_byte = arg_q[31:24];
            3'd2:    frame_byte = arg_q[23:16];
            3'd3:    frame_byte = arg_q[15:8];
            3'd4:    frame_byte = arg_q[7:0];
            3'd5:    frame_byte = {crc_q, 1'b1};
            default: frame_byte = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= StDummyIssue;
            cmd_ready    <= 1'b0;
            busy         <= 1'b1;
            resp_valid   <= 1'b0;
            resp_r1      <= 8'hFF;
            resp_timeout <= 1'b0;
            byte_start   <= 1'b0;
            byte_tx      <= 8'hFF;
            dummy_cnt    <= '0;
            poll_cnt     <= '0;
            byte_idx     <= '0;
            idx_q        <= '0;
            arg_q        <= '0;
            crc_q        <= '0;
        end else begin
            byte_start <= 1'b0;
            resp_valid <= 1'b0;
            unique case (state)
                StDummyIssue: begin
                    byte_tx    <= 8'hFF;
                    byte_start <= 1'b1;
                    state      <= StDummyWait;
                end
                StDummyWait: begin
                    if (byte_done) begin
                        dummy_cnt <= dummy_cnt + 1'b1;
                        if (dummy_cnt == DummyLast) begin
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= StIdle;
                        end else begin
                            state <= StDummyIssue;
                        end
                    end
                end
                StIdle: begin
                    if (cmd_valid) begin
                        idx_q     <= cmd_idx;
                        arg_q     <= cmd_arg;
                        crc_q     <= cmd_crc;
                        byte_idx  <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= StSendIssue;
                    end
                end
                StSendIssue: begin
                    byte_tx    <= frame_byte;
                    byte_start <= 1'b1;
                    state      <= StSendWait;
                end
                StSendWait: begin
                    // Whatever the card clocks back during the frame itself is not a response.
                    if (byte_done) begin
                        if (byte_idx == 3'd5) begin
                            poll_cnt <= '0;
                            state    <= StPollIssue;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            state    <= StSendIssue;
                        end
                    end
                end
                StPollIssue: begin
                    byte_tx    <= 8'hFF;
                    byte_start <= 1'b1;
                    state      <= StPollWait;
                end
                StPollWait: begin
                    if (byte_done) begin
                        poll_cnt <= poll_cnt + 1'b1;
                        if (!byte_rx[7]) begin
                            resp_r1      <= byte_rx;
                            resp_timeout <= 1'b0;
                            resp_valid   <= 1'b1;
                            state        <= StResp;
                        end else if (poll_cnt == PollLast) begin
                            resp_r1      <= 8'hFF;
                            resp_timeout <= 1'b1;
                            resp_valid   <= 1'b1;
                            state        <= StResp;
                        end else begin
                            state <= StPollIssue;
                        end
                    end
                end
                StResp: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= StIdle;
                end
                default: state <= StDummyIssue;
            endcase
        end
    end

endmodule
